// File: rtl/gray2bcd_pkg.sv
// Shared types and helpers for the Gray-coded decimal receiver.
package gray2bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Reflected-binary Gray to binary, MSB first.
  function automatic logic [3:0] gray2bin4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray2bcd_digit.sv
// Combinational single-digit Gray decoder with legal-range (0-9) check.
module gray2bcd_digit
  import gray2bcd_pkg::*;
(
  input  logic [3:0] gray,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    bcd     = gray2bin4(gray);
    invalid = (bcd > BCD_MAX);
  end

endmodule

// File: rtl/gray2bcd_rx.sv
// Gray-coded decimal digit receiver: packs NDIGITS decoded digits (MS first) into one BCD word.
// Optional saturating invalid-digit counter enabled by defining GRAY2BCD_ERRCNT_EN.
module gray2bcd_rx
  import gray2bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_gray,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic                   out_err
`ifdef GRAY2BCD_ERRCNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  localparam int unsigned CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned BW = 4 * NDIGITS;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic            err_q, err_d;
  logic            in_ready_d, out_valid_d;
  logic [3:0]      dig_bcd;
  logic            dig_inv;
  logic            in_hs;

  gray2bcd_digit u_digit (
    .gray    (in_gray),
    .bcd     (dig_bcd),
    .invalid (dig_inv)
  );

  assign in_hs = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next state, datapath updates and next handshake flags
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_hs) begin
          acc_d = (acc_q << 4) | BW'(dig_bcd);
          err_d = err_q | dig_inv;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          err_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == HOLD);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  assign out_bcd = acc_q;
  assign out_err = err_q;

`ifdef GRAY2BCD_ERRCNT_EN
  // Lifetime count of rejected-range digits; survives word completion, saturates at 255
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (in_hs && dig_inv && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray2bcd_rx.sv
// Directed self-checking bench for gray2bcd_rx (NDIGITS=4 and NDIGITS=1 instances).
module tb_gray2bcd_rx;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  in_gray;
  logic [15:0] out_bcd;
  logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [3:0]  in_gray1;
  logic [3:0]  out_bcd1;
`ifdef GRAY2BCD_ERRCNT_EN
  logic [7:0]  err_count, err_count1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray2bcd_rx #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err)
`ifdef GRAY2BCD_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  gray2bcd_rx #(.NDIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_gray   (in_gray1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_bcd   (out_bcd1),
    .out_err   (out_err1)
`ifdef GRAY2BCD_ERRCNT_EN
    ,
    .err_count (err_count1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Offer one digit to the 4-digit instance and wait (bounded) for its handshake
  task automatic send(input logic [3:0] g);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_gray  = g;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_q[$];
  logic [15:0] cur;
  logic [3:0]  d;
  int          nd, pushed, done, cyc, words1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_gray = 4'h0; out_ready = 1'b0;
    rst1 = 1'b1; in_valid1 = 1'b0; in_gray1 = 4'h0; out_ready1 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd",   32'(out_bcd),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);

    // Word 1234, in_valid held high
    send(4'b0001); send(4'b0011); send(4'b0010);
    chk("w1_not_yet", 32'(out_valid), 32'd0);
    send(4'b0110);
    chk("w1_valid", 32'(out_valid), 32'd1);
    chk("w1_bcd",   32'(out_bcd),   32'h1234);
    chk("w1_err",   32'(out_err),   32'd0);
    release_word();
    chk("w1_rel_in_ready",  32'(in_ready),  32'd1);
    chk("w1_rel_out_valid", 32'(out_valid), 32'd0);

    // Word 9870 held under backpressure while a digit is offered
    send(4'b1101); send(4'b1100); send(4'b0100); send(4'b0000);
    in_valid = 1'b1;
    in_gray  = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk("w2_hold_bcd",      32'(out_bcd),   32'h9870);
      chk("w2_hold_in_ready", 32'(in_ready),  32'd0);
      chk("w2_hold_valid",    32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    release_word();
    chk("w2_rel_in_ready", 32'(in_ready), 32'd1);

    // Word with an out-of-range digit
    send(4'b0000); send(4'b1111); send(4'b0001); send(4'b0011);
    chk("w3_bcd", 32'(out_bcd), 32'h0A12);
    chk("w3_err", 32'(out_err), 32'd1);
`ifdef GRAY2BCD_ERRCNT_EN
    chk("w3_err_count", 32'(err_count), 32'd1);
`endif
    release_word();
    send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
    chk("w4_bcd", 32'(out_bcd), 32'h1234);
    chk("w4_err", 32'(out_err), 32'd0);
`ifdef GRAY2BCD_ERRCNT_EN
    chk("w4_err_count", 32'(err_count), 32'd1);
`endif
    release_word();

    // 100 random legal words with random gaps and backpressure
    cur = 16'h0; nd = 0; pushed = 0; done = 0; cyc = 0;
    while (done < 100 && cyc < 20000) begin
      in_valid  = (pushed < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      d         = 4'($urandom_range(0, 9));
      in_gray   = to_gray(d);
      out_ready = 1'($urandom_range(0, 1));
      chk("rnd_ready_vs_valid", 32'(in_ready && out_valid), 32'd0);
      if (in_valid && in_ready) begin
        cur = {cur[11:0], d};
        nd++;
        if (nd == 4) begin
          exp_q.push_back(cur);
          pushed++;
          nd = 0;
        end
      end
      if (out_valid && out_ready) begin
        chk("rnd_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("rnd_word", 32'(out_bcd), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        chk("rnd_err", 32'(out_err), 32'd0);
        done++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_words_done", 32'(done), 32'd100);
`ifdef GRAY2BCD_ERRCNT_EN
    chk("rnd_err_count", 32'(err_count), 32'd1);
`endif

    // Reset mid-word discards the partial word
    send(4'b1101); send(4'b1100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_bcd",   32'(out_bcd),   32'd0);
`ifdef GRAY2BCD_ERRCNT_EN
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
    send(4'b0111); send(4'b0101); send(4'b0100); send(4'b1100);
    chk("w5_bcd", 32'(out_bcd), 32'h5678);
    chk("w5_err", 32'(out_err), 32'd0);
    release_word();

    // Single-digit instance
    rst1 = 1'b0;
    in_valid1 = 1'b1;
    in_gray1  = 4'b1101;
    tick();
    chk("n1_valid",    32'(out_valid1), 32'd1);
    chk("n1_bcd",      32'(out_bcd1),   32'h9);
    chk("n1_in_ready", 32'(in_ready1),  32'd0);
`ifdef GRAY2BCD_ERRCNT_EN
    chk("n1_err_count", 32'(err_count1), 32'd0);
`endif
    out_ready1 = 1'b1;
    in_gray1   = 4'b0011;
    words1 = 0;
    for (int i = 0; i < 10; i++) begin
      chk("n1_alternate", 32'(in_ready1 ^ out_valid1), 32'd1);
      if (out_valid1 && out_ready1) words1++;
      tick();
    end
    chk("n1_words_in_10", 32'(words1), 32'd5);
    chk("n1_last_bcd", 32'(out_bcd1), 32'h2);
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
